pio_ext: RTL and testbench
==========================

PIO_EXT -- requirements
Module: pio_ext

Interface
REQ-001 SHALL have parameter IN_W, default 2: input channel count, 1..32.
REQ-002 SHALL have parameter OUT_W, default 8: output channel count, 1..32.
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 50000: stable cycles before an input change is accepted, >=2.
REQ-004 SHALL have parameter PWM_BITS, default 8: PWM counter width, 1..16.
REQ-005 SHALL have port clk_clk, input, 1: single clock; all logic in this domain.
REQ-006 SHALL have port reset_reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port avs_address, input, 3: register word offset.
REQ-008 SHALL have ports avs_read and avs_write, input, 1 each: Avalon-MM strobes.
REQ-009 SHALL have ports avs_writedata, input, 32, and avs_readdata, output, 32.
REQ-010 SHALL have port in_export, input, IN_W: asynchronous external inputs (keys/switches).
REQ-011 SHALL have port out_export, output, OUT_W: PWM-gated outputs (LEDs).
REQ-012 SHALL have port irq, output, 1: level interrupt.

Function
REQ-013 SHALL use register map: 0 DATA_IN (RO), 1 DATA_OUT (RW), 2 IRQ_MASK (RW), 3 EDGE_CAP (RW1C), 4 EDGE_MODE (RW, 0=rising, 1=falling per bit), 5 PWM_DUTY (RW, PWM_BITS+1 bits); offsets 6-7 read 0 and ignore writes.
REQ-014 SHALL return avs_readdata one cycle after avs_read (fixed read latency 1); unused upper bits read 0; writes take effect on the clock edge of avs_write.
REQ-015 SHALL pass each in_export bit through a two-flop synchroniser before debounce.
REQ-016 SHALL, per channel, hold a counter that clears while synced input equals stable value and increments while it differs; at count DEBOUNCE_CYC-1 the stable bit SHALL take the synced value and the counter clear.
REQ-017 SHALL clear the counter on any bounce back to the stable value, so glitches shorter than DEBOUNCE_CYC cycles never change the stable value.
REQ-018 SHALL expose debounced stable values on DATA_IN; in_export-to-DATA_IN latency = 2 + DEBOUNCE_CYC cycles for a clean step.
REQ-019 SHALL set EDGE_CAP[i] for one stable-value transition matching EDGE_MODE[i]; bits stay set until cleared by writing 1.
REQ-020 SHALL give set priority when an edge and a write-1-clear hit the same bit in the same cycle.
REQ-021 SHALL drive irq = OR over i of (EDGE_CAP[i] AND IRQ_MASK[i]), registered (one cycle after EDGE_CAP changes).
REQ-022 SHALL run a free-running PWM_BITS counter wrapping 2^PWM_BITS-1 -> 0.
REQ-023 SHALL drive out_export[i] = DATA_OUT[i] AND (pwm_cnt < duty), registered; duty = 2^PWM_BITS gives constant on, 0 constant off.
REQ-024 SHALL saturate PWM_DUTY writes above 2^PWM_BITS to 2^PWM_BITS.

Reset
REQ-025 SHALL on reset_reset_n low asynchronously clear synchronisers, stable values, debounce counters, DATA_OUT, IRQ_MASK, EDGE_CAP, EDGE_MODE, pwm_cnt, avs_readdata, out_export and irq to 0.
REQ-026 SHALL reset PWM_DUTY to 2^PWM_BITS (full on) so the block behaves as a plain PIO without software setup.
REQ-027 SHALL not generate an edge on the first stable update after reset unless that update matches EDGE_MODE against reset value 0.
REQ-028 SHALL release reset synchronously to clk_clk externally; the block relies on that.

Structure
REQ-029 SHALL place register offset constants and the PWM full-scale helper in shared package pio_ext_pkg.
REQ-030 SHALL implement synchroniser plus debounce per bit in sub-module pio_debounce, instantiated IN_W times.

Verification (IN_W=2, OUT_W=8, DEBOUNCE_CYC=4, PWM_BITS=4)
REQ-031 SHALL test: in_export[0] 0->1 held -> DATA_IN=1 after 6 cycles, EDGE_CAP=0x1; 3-cycle pulse -> DATA_IN unchanged, EDGE_CAP=0.
REQ-032 SHALL test: IRQ_MASK=0x1, rising edge ch0 -> irq=1; write EDGE_CAP=0x1 -> irq=0 one cycle later.
REQ-033 SHALL test: EDGE_MODE=0x2, ch1 1->0 -> EDGE_CAP=0x2; ch1 0->1 -> no new capture.
REQ-034 SHALL test: DATA_OUT=0xFF, PWM_DUTY=4 -> each out bit high 4 of every 16 cycles; duty 0 -> always 0; write 0x20 -> reads back 16, always on.
REQ-035 SHALL test: same-cycle edge and W1C on bit 0 -> EDGE_CAP[0] stays 1; reset asserted mid-debounce -> all outputs 0 immediately, PWM_DUTY reads 16.

Source files
------------

// File: rtl/pio_ext_pkg.sv
// Shared register offsets and PWM full-scale helper for the PIO extension block.
package pio_ext_pkg;

  localparam logic [2:0] REG_DATA_IN   = 3'd0;
  localparam logic [2:0] REG_DATA_OUT  = 3'd1;
  localparam logic [2:0] REG_IRQ_MASK  = 3'd2;
  localparam logic [2:0] REG_EDGE_CAP  = 3'd3;
  localparam logic [2:0] REG_EDGE_MODE = 3'd4;
  localparam logic [2:0] REG_PWM_DUTY  = 3'd5;

  // Duty value meaning "always on" for a counter of the given width.
  function automatic logic [31:0] pwm_full(input int bits);
    return 32'd1 << bits;
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input channel: two-flop synchroniser followed by a stability counter.
// The stable value changes only after DEBOUNCE_CYC consecutive differing samples.
module pio_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYC);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // Any return to the stable value restarts the count, rejecting short glitches.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_ext.sv
// Avalon-MM PIO with debounced inputs, edge capture/interrupt and PWM-gated outputs.
module pio_ext
  import pio_ext_pkg::*;
#(
  parameter int IN_W         = 2,
  parameter int OUT_W        = 8,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int PWM_BITS     = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [IN_W-1:0]  in_export,
  output logic [OUT_W-1:0] out_export,
  output logic             irq
);

  localparam logic [31:0] FULL = pwm_full(PWM_BITS);

  logic [IN_W-1:0]     stable, stable_d, edge_hit, clr_mask;
  logic [IN_W-1:0]     irq_mask, edge_cap, edge_mode;
  logic [OUT_W-1:0]    data_out;
  logic [PWM_BITS:0]   duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [31:0]         rd_mux;
  logic                pwm_on;
  logic                unused_ok;

  assign unused_ok = ^avs_writedata;

  for (genvar i = 0; i < IN_W; i++) begin : g_db
    pio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .din   (in_export[i]),
      .stable(stable[i])
    );
  end

  // A transition counts when the new stable value is 1 (rising) or 0 (falling).
  assign edge_hit = (stable ^ stable_d) & (stable ^ edge_mode);
  assign clr_mask = (avs_write && avs_address == REG_EDGE_CAP) ? avs_writedata[IN_W-1:0] : '0;
  assign pwm_on   = {1'b0, pwm_cnt} < duty;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      REG_DATA_IN:   rd_mux[IN_W-1:0]   = stable;
      REG_DATA_OUT:  rd_mux[OUT_W-1:0]  = data_out;
      REG_IRQ_MASK:  rd_mux[IN_W-1:0]   = irq_mask;
      REG_EDGE_CAP:  rd_mux[IN_W-1:0]   = edge_cap;
      REG_EDGE_MODE: rd_mux[IN_W-1:0]   = edge_mode;
      REG_PWM_DUTY:  rd_mux[PWM_BITS:0] = duty;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_d     <= '0;
      data_out     <= '0;
      irq_mask     <= '0;
      edge_cap     <= '0;
      edge_mode    <= '0;
      duty         <= FULL[PWM_BITS:0];
      pwm_cnt      <= '0;
      avs_readdata <= '0;
      out_export   <= '0;
      irq          <= 1'b0;
    end else begin
      stable_d   <= stable;
      // New edges win over a simultaneous write-1-to-clear.
      edge_cap   <= (edge_cap & ~clr_mask) | edge_hit;
      irq        <= |(edge_cap & irq_mask);
      pwm_cnt    <= pwm_cnt + 1'b1;
      out_export <= data_out & {OUT_W{pwm_on}};
      if (avs_read) avs_readdata <= rd_mux;
      if (avs_write) begin
        case (avs_address)
          REG_DATA_OUT:  data_out  <= avs_writedata[OUT_W-1:0];
          REG_IRQ_MASK:  irq_mask  <= avs_writedata[IN_W-1:0];
          REG_EDGE_MODE: edge_mode <= avs_writedata[IN_W-1:0];
          REG_PWM_DUTY:  duty      <= (avs_writedata > FULL) ? FULL[PWM_BITS:0]
                                                             : avs_writedata[PWM_BITS:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_ext.sv
// Directed bench for pio_ext with IN_W=2, OUT_W=8, DEBOUNCE_CYC=4, PWM_BITS=4.
module tb_pio_ext;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic [1:0]  in_export = '0;
  logic [7:0]  out_export;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  pio_ext #(.IN_W(2), .OUT_W(8), .DEBOUNCE_CYC(4), .PWM_BITS(4)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .in_export    (in_export),
    .out_export   (out_export),
    .irq          (irq)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if (avs_readdata !== 32'd0 || out_export !== 8'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: rd=%h out=%h irq=%b, want 0/0/0", avs_readdata, out_export, irq);
    end
    rst_n = 1'b1;
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'd16) begin failures++; $display("FAIL reset_duty: got %0d want 16", rd); end
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL unused_offset: got %h want 0", rd); end
  endtask

  task automatic test_debounce;
    in_export[0] = 1'b1;
    tick(5);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL din_early: got %h want 0", rd); end
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 32'd1) begin failures++; $display("FAIL din_after6: got %h want 1", rd); end
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'd1) begin failures++; $display("FAIL cap_rise: got %h want 1", rd); end
    bus_write(3'd3, 32'd1);
    in_export[0] = 1'b0;
    tick(10);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL cap_fall_ignored: got %h want 0", rd); end
    in_export[0] = 1'b1;
    tick(3);
    in_export[0] = 1'b0;
    tick(10);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL pulse_din: got %h want 0", rd); end
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL pulse_cap: got %h want 0", rd); end
  endtask

  task automatic test_irq;
    bus_write(3'd2, 32'd1);
    in_export[0] = 1'b1;
    tick(10);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set: got %b want 1", irq); end
    bus_write(3'd3, 32'd1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_lag: got %b want 1", irq); end
    tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b want 0", irq); end
    in_export[0] = 1'b0;
    tick(10);
  endtask

  task automatic test_edge_mode;
    bus_write(3'd4, 32'd2);
    in_export[1] = 1'b1;
    tick(10);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL fall_mode_rise: got %h want 0", rd); end
    in_export[1] = 1'b0;
    tick(10);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'd2) begin failures++; $display("FAIL fall_mode_fall: got %h want 2", rd); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_masked: got %b want 0", irq); end
    bus_write(3'd3, 32'd2);
    in_export[1] = 1'b1;
    tick(10);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL fall_mode_norecap: got %h want 0", rd); end
  endtask

  task automatic test_pwm;
    int highs;
    int bad;
    bus_write(3'd1, 32'hFF);
    bus_write(3'd5, 32'd4);
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'd4) begin failures++; $display("FAIL duty4_read: got %0d want 4", rd); end
    tick(2);
    highs = 0; bad = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (out_export === 8'hFF) highs++;
      else if (out_export !== 8'h00) bad++;
    end
    checks++;
    if (highs != 8 || bad != 0) begin
      failures++;
      $display("FAIL pwm_duty4: highs=%0d bad=%0d want 8/0 over 32", highs, bad);
    end
    bus_write(3'd5, 32'd0);
    tick(2);
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (out_export !== 8'h00) highs++;
    end
    checks++;
    if (highs != 0) begin failures++; $display("FAIL pwm_duty0: nonzero=%0d want 0", highs); end
    bus_write(3'd5, 32'h20);
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'd16) begin failures++; $display("FAIL duty_sat: got %0d want 16", rd); end
    tick(2);
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (out_export !== 8'hFF) highs++;
    end
    checks++;
    if (highs != 0) begin failures++; $display("FAIL pwm_full: not_ff=%0d want 0", highs); end
  endtask

  task automatic test_same_cycle;
    in_export[0] = 1'b1;
    tick(6);
    bus_write(3'd3, 32'd1);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'd1) begin failures++; $display("FAIL set_priority: got %h want 1", rd); end
  endtask

  task automatic test_reset_mid;
    tick(2);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    bus_read(3'd1, rd);
    in_export[0] = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (avs_readdata !== 32'd0 || out_export !== 8'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: rd=%h out=%h irq=%b, want 0/0/0", avs_readdata, out_export, irq);
    end
    tick(2);
    rst_n = 1'b1;
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'd16) begin failures++; $display("FAIL mid_reset_duty: got %0d want 16", rd); end
    tick(10);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'd2) begin failures++; $display("FAIL post_reset_edge: got %h want 2", rd); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL post_reset_irq: got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_irq();
    test_edge_mode();
    test_pwm();
    test_same_cycle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
